// File: rtl/pcie_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_perf_monitor
//  Description : Passive PCIe AXI-Stream performance monitor. It snoops the TX
//                and RX streams and counts accepted payload bytes
//                (4 x popcount(tkeep)) and completed packets (tlast beats)
//                over a programmable interval of clk cycles. At the end of
//                each interval it publishes scaled, saturated 32-bit snapshots
//                and a one-cycle sample_pulse.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                clk_period_reg      - interval length (clamped to C_MIN_PERIOD)
//                scaling_factor      - byte-count right shift = 2*scaling_factor
//                tx_* / rx_*         - snooped stream handshake, keep and last
//                tx/rx_pcie_bc       - scaled byte count of the last interval
//                tx/rx_pcie_pc       - packet count of the last interval
//                sample_pulse        - strobe in the cycle the outputs update
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_perf_monitor #(
    parameter int C_DATA_WIDTH = 256,
    parameter int C_KEEP_WIDTH = C_DATA_WIDTH / 32,
    parameter int C_ACC_WIDTH  = 40,
    parameter int C_MIN_PERIOD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             clk_period_reg,
    input  logic [1:0]              scaling_factor,
    input  logic                    tx_tvalid,
    input  logic                    tx_tready,
    input  logic [C_KEEP_WIDTH-1:0] tx_tkeep,
    input  logic                    tx_tlast,
    input  logic                    rx_tvalid,
    input  logic                    rx_tready,
    input  logic [C_KEEP_WIDTH-1:0] rx_tkeep,
    input  logic                    rx_tlast,
    output logic [31:0]             tx_pcie_bc,
    output logic [31:0]             rx_pcie_bc,
    output logic [31:0]             tx_pcie_pc,
    output logic [31:0]             rx_pcie_pc,
    output logic                    sample_pulse
);

    // Width able to hold the byte count of one full beat.
    localparam int BEAT_W = $clog2(4 * C_KEEP_WIDTH + 1);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [BEAT_W-1:0] beat_bytes(input logic [C_KEEP_WIDTH-1:0] keep);
        logic [BEAT_W-1:0] n;
        n = '0;
        for (int i = 0; i < C_KEEP_WIDTH; i++) begin
            n = n + BEAT_W'(keep[i]);
        end
        return n << 2;
    endfunction

    function automatic logic [C_ACC_WIDTH-1:0] sat_add_bc(input logic [C_ACC_WIDTH-1:0] a,
                                                          input logic [BEAT_W-1:0]      b);
        logic [C_ACC_WIDTH:0] s;
        s = {1'b0, a} + (C_ACC_WIDTH + 1)'(b);
        return s[C_ACC_WIDTH] ? '1 : s[C_ACC_WIDTH-1:0];
    endfunction

    function automatic logic [31:0] sat_add_pc(input logic [31:0] a, input logic b);
        return (a == 32'hFFFF_FFFF) ? a : a + 32'(b);
    endfunction

    function automatic logic [31:0] scale_bc(input logic [C_ACC_WIDTH-1:0] v,
                                             input logic [1:0]             sf);
        logic [C_ACC_WIDTH-1:0] sh;
        sh = v >> {sf, 1'b0};
        return (|sh[C_ACC_WIDTH-1:32]) ? 32'hFFFF_FFFF : sh[31:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]            timer_q,      timer_d;
    logic [31:0]            period_q,     period_d;
    logic [31:0]            period_cur;
    logic                   expire;

    logic [BEAT_W-1:0]      tx_s1_bytes_q, tx_s1_bytes_d;
    logic [BEAT_W-1:0]      rx_s1_bytes_q, rx_s1_bytes_d;
    logic                   tx_s1_pkt_q,   tx_s1_pkt_d;
    logic                   rx_s1_pkt_q,   rx_s1_pkt_d;
    logic                   tag_s1_q,      tag_s1_d;

    logic [C_ACC_WIDTH-1:0] tx_bc_acc_q,   tx_bc_acc_d;
    logic [C_ACC_WIDTH-1:0] rx_bc_acc_q,   rx_bc_acc_d;
    logic [31:0]            tx_pc_acc_q,   tx_pc_acc_d;
    logic [31:0]            rx_pc_acc_q,   rx_pc_acc_d;
    logic [C_ACC_WIDTH-1:0] tx_bc_snap_q,  tx_bc_snap_d;
    logic [C_ACC_WIDTH-1:0] rx_bc_snap_q,  rx_bc_snap_d;
    logic [31:0]            tx_pc_snap_q,  tx_pc_snap_d;
    logic [31:0]            rx_pc_snap_q,  rx_pc_snap_d;
    logic [1:0]             shift_q,       shift_d;
    logic                   tag_s2_q,      tag_s2_d;

    logic [31:0]            tx_bc_q,       tx_bc_d;
    logic [31:0]            rx_bc_q,       rx_bc_d;
    logic [31:0]            tx_pc_q,       tx_pc_d;
    logic [31:0]            rx_pc_q,       rx_pc_d;
    logic                   pulse_q,       pulse_d;

    logic [C_ACC_WIDTH-1:0] tx_bc_sum, rx_bc_sum;
    logic [31:0]            tx_pc_sum, rx_pc_sum;

    // ------------------------------------------------------------------
    // Interval timer. The period is re-latched only on the cycle the timer
    // sits at 0, so a register change mid-interval waits for the next one.
    // P >= C_MIN_PERIOD > 1, so the start cycle can never also be expiry.
    // ------------------------------------------------------------------
    always_comb begin
        period_cur = period_q;
        if (timer_q == 32'd0) begin
            period_cur = (clk_period_reg < 32'(C_MIN_PERIOD)) ? 32'(C_MIN_PERIOD)
                                                              : clk_period_reg;
        end
        expire   = (timer_q == period_cur - 32'd1);
        period_d = period_cur;
        timer_d  = expire ? 32'd0 : timer_q + 32'd1;
    end

    // ------------------------------------------------------------------
    // Stage 1: per-beat contribution plus the expiry tag of the same cycle,
    // so the beat and the interval boundary stay aligned downstream.
    // ------------------------------------------------------------------
    always_comb begin
        tx_s1_bytes_d = (tx_tvalid && tx_tready) ? beat_bytes(tx_tkeep) : '0;
        rx_s1_bytes_d = (rx_tvalid && rx_tready) ? beat_bytes(rx_tkeep) : '0;
        tx_s1_pkt_d   = tx_tvalid && tx_tready && tx_tlast;
        rx_s1_pkt_d   = rx_tvalid && rx_tready && rx_tlast;
        tag_s1_d      = expire;
    end

    // ------------------------------------------------------------------
    // Stage 2: saturating accumulation. On the tagged cycle the snapshot
    // includes the tagged beat and the accumulator restarts from zero.
    // ------------------------------------------------------------------
    always_comb begin
        tx_bc_sum    = sat_add_bc(tx_bc_acc_q, tx_s1_bytes_q);
        rx_bc_sum    = sat_add_bc(rx_bc_acc_q, rx_s1_bytes_q);
        tx_pc_sum    = sat_add_pc(tx_pc_acc_q, tx_s1_pkt_q);
        rx_pc_sum    = sat_add_pc(rx_pc_acc_q, rx_s1_pkt_q);

        tx_bc_acc_d  = tx_bc_sum;
        rx_bc_acc_d  = rx_bc_sum;
        tx_pc_acc_d  = tx_pc_sum;
        rx_pc_acc_d  = rx_pc_sum;
        tx_bc_snap_d = tx_bc_snap_q;
        rx_bc_snap_d = rx_bc_snap_q;
        tx_pc_snap_d = tx_pc_snap_q;
        rx_pc_snap_d = rx_pc_snap_q;
        shift_d      = shift_q;
        tag_s2_d     = tag_s1_q;

        if (tag_s1_q) begin
            tx_bc_snap_d = tx_bc_sum;
            rx_bc_snap_d = rx_bc_sum;
            tx_pc_snap_d = tx_pc_sum;
            rx_pc_snap_d = rx_pc_sum;
            shift_d      = scaling_factor;
            tx_bc_acc_d  = '0;
            rx_bc_acc_d  = '0;
            tx_pc_acc_d  = '0;
            rx_pc_acc_d  = '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: scale and clamp into the 32-bit published registers.
    // ------------------------------------------------------------------
    always_comb begin
        tx_bc_d = tx_bc_q;
        rx_bc_d = rx_bc_q;
        tx_pc_d = tx_pc_q;
        rx_pc_d = rx_pc_q;
        pulse_d = tag_s2_q;
        if (tag_s2_q) begin
            tx_bc_d = scale_bc(tx_bc_snap_q, shift_q);
            rx_bc_d = scale_bc(rx_bc_snap_q, shift_q);
            tx_pc_d = tx_pc_snap_q;
            rx_pc_d = rx_pc_snap_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q       <= '0;
            period_q      <= '0;
            tx_s1_bytes_q <= '0;
            rx_s1_bytes_q <= '0;
            tx_s1_pkt_q   <= 1'b0;
            rx_s1_pkt_q   <= 1'b0;
            tag_s1_q      <= 1'b0;
            tx_bc_acc_q   <= '0;
            rx_bc_acc_q   <= '0;
            tx_pc_acc_q   <= '0;
            rx_pc_acc_q   <= '0;
            tx_bc_snap_q  <= '0;
            rx_bc_snap_q  <= '0;
            tx_pc_snap_q  <= '0;
            rx_pc_snap_q  <= '0;
            shift_q       <= '0;
            tag_s2_q      <= 1'b0;
            tx_bc_q       <= '0;
            rx_bc_q       <= '0;
            tx_pc_q       <= '0;
            rx_pc_q       <= '0;
            pulse_q       <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            period_q      <= period_d;
            tx_s1_bytes_q <= tx_s1_bytes_d;
            rx_s1_bytes_q <= rx_s1_bytes_d;
            tx_s1_pkt_q   <= tx_s1_pkt_d;
            rx_s1_pkt_q   <= rx_s1_pkt_d;
            tag_s1_q      <= tag_s1_d;
            tx_bc_acc_q   <= tx_bc_acc_d;
            rx_bc_acc_q   <= rx_bc_acc_d;
            tx_pc_acc_q   <= tx_pc_acc_d;
            rx_pc_acc_q   <= rx_pc_acc_d;
            tx_bc_snap_q  <= tx_bc_snap_d;
            rx_bc_snap_q  <= rx_bc_snap_d;
            tx_pc_snap_q  <= tx_pc_snap_d;
            rx_pc_snap_q  <= rx_pc_snap_d;
            shift_q       <= shift_d;
            tag_s2_q      <= tag_s2_d;
            tx_bc_q       <= tx_bc_d;
            rx_bc_q       <= rx_bc_d;
            tx_pc_q       <= tx_pc_d;
            rx_pc_q       <= rx_pc_d;
            pulse_q       <= pulse_d;
        end
    end

    assign tx_pcie_bc   = tx_bc_q;
    assign rx_pcie_bc   = rx_bc_q;
    assign tx_pcie_pc   = tx_pc_q;
    assign rx_pcie_pc   = rx_pc_q;
    assign sample_pulse = pulse_q;

endmodule
`default_nettype wire

// File: doc/pcie_perf_monitor.md
Name: pcie_perf_monitor

Overview:
- Upstream feeder of the user register block's PCIe performance-monitor registers (TX/RX byte count, TX/RX packet count).
- Passively snoops the TX and RX PCIe AXI-Stream interfaces.
- Accumulates accepted payload bytes and completed packets over a programmable interval of clk cycles.
- At each interval end, publishes scaled, saturated 32-bit snapshots that the register block reads.
- Interval length (clk_period_reg) and scaling_factor are sourced from the register block's writable registers.

Parameters:
C_DATA_WIDTH, 256, stream data width in bits; legal values 64/128/256/512.
C_KEEP_WIDTH, C_DATA_WIDTH/32, dword-granular keep width.
C_ACC_WIDTH, 40, internal byte-accumulator width.
C_MIN_PERIOD, 16, minimum interval length in cycles.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clk_period_reg  in  32  interval length in clk cycles
scaling_factor  in  2  byte-count right-shift select
tx_tvalid  in  1  TX stream valid (snooped)
tx_tready  in  1  TX stream ready (snooped)
tx_tkeep  in  C_KEEP_WIDTH  TX dword keep
tx_tlast  in  1  TX end of packet
rx_tvalid  in  1  RX stream valid
rx_tready  in  1  RX stream ready
rx_tkeep  in  C_KEEP_WIDTH  RX dword keep
rx_tlast  in  1  RX end of packet
tx_pcie_bc  out  32  TX bytes in last interval, scaled
rx_pcie_bc  out  32  RX bytes in last interval, scaled
tx_pcie_pc  out  32  TX packets in last interval
rx_pcie_pc  out  32  RX packets in last interval
sample_pulse  out  1  one-cycle strobe when outputs update

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. While rst_n=0, all outputs are 0, all accumulators and the pipeline are 0, and the timer is 0. Reset mid-interval discards all partial counts; the first interval starts on the first cycle with rst_n=1.
- Beat acceptance:
  - A beat counts only when tvalid & tready.
  - Bytes per beat = 4 × popcount(tkeep).
  - Packet increment = 1 when the accepted beat has tlast=1.
  - tvalid without tready counts nothing.
- Interval timer:
  - At interval start, latch P = max(clk_period_reg, C_MIN_PERIOD).
  - Timer counts 0..P-1. The expiry cycle E is the cycle where timer = P-1; the timer wraps to 0 on the next cycle.
  - A clk_period_reg change mid-interval takes effect only at the next interval start.
- Interval membership: beats accepted in cycles up to and including E belong to the ending interval. Beats accepted at E+1 belong to the new interval.
- Pipeline:
  - Stage 1 registers the per-side beat byte count, packet increment and the expiry tag.
  - Stage 2 accumulates.
  - The tag travels with the data, so the boundary is exact with no lost or double-counted beat.
  - On the tagged accumulate cycle, the snapshot is taken of accumulator + tagged beat, and the accumulator reloads to 0.
- Output update: outputs and sample_pulse become visible at cycle E+3. sample_pulse is high for exactly one cycle per interval; outputs hold until the next update.
- Byte scaling:
  - Shift = 2 × scaling_factor: 00 → >>0, 01 → >>2, 10 → >>4, 11 → >>6.
  - scaling_factor is sampled at the snapshot cycle.
  - If the shifted value exceeds 32'hFFFFFFFF, output 32'hFFFFFFFF.
- Saturation:
  - Byte accumulators (C_ACC_WIDTH) saturate at all-ones and never wrap.
  - Packet accumulators are 32-bit and saturate at 32'hFFFFFFFF.
- Independence and simultaneous events: TX and RX are fully independent. Simultaneous beats on both sides, and a beat coinciding with expiry, are all handled per the membership rule above.
- No backpressure: the block never drives ready.

Test Plan:
1. C_DATA_WIDTH=256, clk_period_reg=100, scaling_factor=00; 10 TX beats with tkeep=8'hFF, tlast every 2nd beat, tready=1 -> first sample_pulse: tx_pcie_bc=320, tx_pcie_pc=5, rx_pcie_bc=0, rx_pcie_pc=0; pulse is 1 cycle wide, 3 cycles after E.
2. Same traffic with scaling_factor=10 -> tx_pcie_bc=20. With scaling_factor=11 -> tx_pcie_bc=5.
3. RX: 6 cycles tvalid=1 with tready=0, then 4 accepted beats with tkeep=8'h0F, tlast on the last -> rx_pcie_bc=64, rx_pcie_pc=1.
4. Boundary: one TX beat (32 bytes, tlast) accepted exactly at E and one at E+1 -> interval n reports bc=32, pc=1; interval n+1 reports bc=32, pc=1.
5. clk_period_reg=5 -> intervals are 16 cycles apart (clamp to C_MIN_PERIOD). Change to 200 mid-interval -> current interval stays 16; the next interval is 200.
6. Reset: assert rst_n=0 mid-interval after 50 beats -> all outputs 0 and no sample_pulse. After release, a fresh interval reports only post-reset traffic. Separately, force the byte accumulator near 2^40 -> output 32'hFFFFFFFF at scaling 00.
